// File: rtl/sr_dmem_arbiter.sv
// sr_dmem_arbiter
//   Shares one synchronous single-port data RAM between the CPU data port (C)
//   and a debug/loader port (D). Arbitration is round-robin (FAIR=1) or fixed
//   CPU priority (FAIR=0). Byte/half/word accesses are turned into a word
//   address, byte enables and lane-replicated write data; read data is
//   extracted from the addressed lane and sign- or zero-extended.
//
//   Writes and misaligned accesses complete in the request cycle. Reads strobe
//   the RAM in IDLE and are acknowledged one cycle later in RD, once mem_rdata
//   is valid.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   c_req .. c_sign     CPU request and its fields (held until c_ack)
//   c_ack, c_rdata      completion pulse and extended read data
//   c_err               misaligned access, qualified by c_ack
//   d_*                 same set for the debug/loader requester
//   mem_en, mem_we      RAM strobe and write enable
//   mem_addr, mem_be    RAM word address and byte enables
//   mem_wdata           lane-aligned write data
//   mem_rdata           RAM read data, valid the cycle after a read strobe

module sr_dmem_arbiter #(
  parameter int AW   = 10,
  parameter bit FAIR = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [31:0]   c_addr,
  input  logic [31:0]   c_wdata,
  input  logic [1:0]    c_size,
  input  logic          c_sign,
  output logic          c_ack,
  output logic [31:0]   c_rdata,
  output logic          c_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [1:0]    d_size,
  input  logic          d_sign,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] RD    = 1'b1;
  localparam logic       SEL_C = 1'b0;
  localparam logic       SEL_D = 1'b1;

  logic [0:0] state, state_nxt;
  logic       last, last_nxt;
  logic       rd_id, rd_sign, rd_capture;
  logic [1:0] rd_off, rd_size;

  logic        win;
  logic        s_we, s_sign, misaligned;
  logic [31:0] s_addr, s_wdata;
  logic [1:0]  s_size;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;

  logic        ack, ack_id, err;
  logic [31:0] rdata;

  // Upper address bits do not reach the RAM; the address wraps modulo 2^AW.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c_addr[31:AW+2], d_addr[31:AW+2]};

  // Pull the addressed byte or half down to bit 0 and extend it.
  // Size 11 falls through to the word case.
  function automatic logic [31:0] extend(input logic [31:0] raw,
                                         input logic [1:0]  off,
                                         input logic [1:0]  size,
                                         input logic        sign);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = '0;
    res = raw;
    case (size)
      2'b00: begin
        sh  = raw >> {off, 3'b000};
        res = {{24{sign & sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh  = raw >> {off[1], 4'b0000};
        res = {{16{sign & sh[15]}}, sh[15:0]};
      end
      default: res = raw;
    endcase
    return res;
  endfunction

  // Winner selection. With both requesting, round-robin gives the grant to
  // whoever did not complete last; fixed priority always favours C.
  always_comb begin
    win = SEL_C;
    if (c_req && d_req) begin
      if (FAIR) win = (last == SEL_D) ? SEL_C : SEL_D;
      else      win = SEL_C;
    end else if (d_req) begin
      win = SEL_D;
    end
  end

  assign s_we    = (win == SEL_D) ? d_we    : c_we;
  assign s_addr  = (win == SEL_D) ? d_addr  : c_addr;
  assign s_wdata = (win == SEL_D) ? d_wdata : c_wdata;
  assign s_size  = (win == SEL_D) ? d_size  : c_size;
  assign s_sign  = (win == SEL_D) ? d_sign  : c_sign;

  assign misaligned = ((s_size == 2'b01) && s_addr[0]) ||
                      (s_size[1] && (s_addr[1:0] != 2'b00));

  // Byte enables and replicated write data so the RAM sees the value on
  // every lane and only the enabled lanes are written.
  always_comb begin
    case (s_size)
      2'b00: begin
        lane_be    = 4'b0001 << s_addr[1:0];
        lane_wdata = {4{s_wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = s_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{s_wdata[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = s_wdata;
      end
    endcase
  end

  // Main control. Everything stays at 0 while rst_n is low so a held request
  // cannot produce an ack or a RAM strobe during reset.
  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    rd_capture = 1'b0;
    ack        = 1'b0;
    ack_id     = SEL_C;
    err        = 1'b0;
    rdata      = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (c_req || d_req) begin
            ack_id = win;
            if (misaligned) begin
              ack      = 1'b1;
              err      = 1'b1;
              last_nxt = win;
            end else if (s_we) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = s_addr[AW+1:2];
              mem_be    = lane_be;
              mem_wdata = lane_wdata;
              ack       = 1'b1;
              last_nxt  = win;
            end else begin
              mem_en     = 1'b1;
              mem_addr   = s_addr[AW+1:2];
              mem_be     = 4'b1111;
              rd_capture = 1'b1;
              state_nxt  = RD;
            end
          end
        end
        RD: begin
          // Completes even if the requester dropped req meanwhile.
          ack       = 1'b1;
          ack_id    = rd_id;
          rdata     = extend(mem_rdata, rd_off, rd_size, rd_sign);
          last_nxt  = rd_id;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign c_ack   = ack & (ack_id == SEL_C);
  assign d_ack   = ack & (ack_id == SEL_D);
  assign c_err   = err & (ack_id == SEL_C);
  assign d_err   = err & (ack_id == SEL_D);
  assign c_rdata = (ack_id == SEL_C) ? rdata : '0;
  assign d_rdata = (ack_id == SEL_D) ? rdata : '0;

  // State, round-robin history and the read context carried into RD.
  // last resets to D so C wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= SEL_D;
      rd_id   <= SEL_C;
      rd_off  <= '0;
      rd_size <= '0;
      rd_sign <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      if (rd_capture) begin
        rd_id   <= win;
        rd_off  <= s_addr[1:0];
        rd_size <= s_size;
        rd_sign <= s_sign;
      end
    end
  end

endmodule

// File: tb/tb_sr_dmem_arbiter.sv
// tb_sr_dmem_arbiter
//   Self-checking bench for sr_dmem_arbiter. A round-robin instance drives a
//   behavioural RAM; a fixed-priority instance shares the same inputs for the
//   arbitration checks. Every access pushes its expected completion into a
//   scoreboard queue which a monitor pops on each ack.

module tb_sr_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c_req, c_we, c_sign;
  logic [31:0] c_addr, c_wdata;
  logic [1:0]  c_size;
  logic        d_req, d_we, d_sign;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;

  logic        c_ack, c_err, d_ack, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  logic        nf_c_ack, nf_c_err, nf_d_ack, nf_d_err;
  logic [31:0] nf_c_rdata, nf_d_rdata;
  logic        nf_mem_en, nf_mem_we;
  logic [9:0]  nf_mem_addr;
  logic [3:0]  nf_mem_be;
  logic [31:0] nf_mem_wdata;

  logic [31:0] ram [0:1023];

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;

  sr_dmem_arbiter #(.AW(10), .FAIR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_size(c_size), .c_sign(c_sign),
    .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_sign(d_sign),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  sr_dmem_arbiter #(.AW(10), .FAIR(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_size(c_size), .c_sign(c_sign),
    .c_ack(nf_c_ack), .c_rdata(nf_c_rdata), .c_err(nf_c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_sign(d_sign),
    .d_ack(nf_d_ack), .d_rdata(nf_d_rdata), .d_err(nf_d_err),
    .mem_en(nf_mem_en), .mem_we(nf_mem_we), .mem_addr(nf_mem_addr),
    .mem_be(nf_mem_be), .mem_wdata(nf_mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous RAM with byte enables, fed by the FAIR instance.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Scoreboard monitor: each ack consumes the oldest expectation.
  always @(negedge clk) begin
    if (c_ack || d_ack) begin
      if (!rst_n) begin
        vectors++; miscompares++;
        $display("[TB] FAIL ack_in_reset: c_ack=%0b d_ack=%0b, required 0", c_ack, d_ack);
      end else if (c_ack && d_ack) begin
        vectors++; miscompares++;
        $display("[TB] FAIL dual_ack: c_ack=1 d_ack=1, required at most one");
      end else if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL unexpected_ack: c_ack=%0b d_ack=%0b, none pending", c_ack, d_ack);
      end else begin
        mon_e = sb.pop_front();
        vectors++;
        if (d_ack !== mon_e.is_d) begin
          miscompares++;
          $display("[TB] FAIL ack_owner: got d=%0b, required d=%0b", d_ack, mon_e.is_d);
        end
        vectors++;
        if ((d_ack ? d_rdata : c_rdata) !== mon_e.rdata) begin
          miscompares++;
          $display("[TB] FAIL rdata: got %08h, required %08h",
                   d_ack ? d_rdata : c_rdata, mon_e.rdata);
        end
        vectors++;
        if ((d_ack ? d_err : c_err) !== mon_e.err) begin
          miscompares++;
          $display("[TB] FAIL err: got %0b, required %0b", d_ack ? d_err : c_err, mon_e.err);
        end
      end
    end
  end

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_size = '0; c_sign = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_size = '0; d_sign = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Drive one access, record its expectation, wait (bounded) for the ack and
  // hand back what the RAM port showed in the request cycle.
  task automatic do_access(input logic is_d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic sign,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                           input string name,
                           output logic f_en, output logic f_we, output logic [9:0] f_addr,
                           output logic [3:0] f_be, output logic [31:0] f_wdata);
    int lat;
    bit got;
    sb.push_back('{is_d: is_d, rdata: exp_rdata, err: exp_err});
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size; d_sign = sign;
    end else begin
      c_req = 1; c_we = we; c_addr = addr; c_wdata = wdata; c_size = size; c_sign = sign;
    end
    got = 0; lat = 0;
    f_en = 0; f_we = 0; f_addr = '0; f_be = '0; f_wdata = '0;
    while (!got && lat < 4) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        f_en = mem_en; f_we = mem_we; f_addr = mem_addr; f_be = mem_be; f_wdata = mem_wdata;
      end
      if (c_ack || d_ack) got = 1;
    end
    @(posedge clk); #1;
    c_req = 0; d_req = 0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: no ack within 4 cycles, required ack after %0d", name, exp_lat);
    end else if (lat != exp_lat) begin
      miscompares++;
      $display("[TB] FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
    end
  endtask

  task automatic test_reset();
    logic [31:0] w;
    rst_n = 0;
    idle_inputs();
    w = 32'hDEADBEEF;
    c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = w; c_size = 2'b10;
    @(negedge clk);
    vectors++;
    if (c_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_c_ack: got %0b, required 0", c_ack); end
    vectors++;
    if (mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_en: got %0b, required 0", mem_en); end
    vectors++;
    if (mem_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_wdata: got %08h, required 0", mem_wdata); end
    idle_inputs();
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    vectors++;
    if ({c_ack, d_ack, mem_en, mem_be} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_outputs: got %07b, required 0", {c_ack, d_ack, mem_en, mem_be});
    end
  endtask

  task automatic test_word_write();
    logic en, we; logic [9:0] a; logic [3:0] be; logic [31:0] wd;
    do_access(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0, 1, "word_wr", en, we, a, be, wd);
    vectors++;
    if ({en, we, a, be} !== {1'b1, 1'b1, 10'd4, 4'b1111}) begin
      miscompares++;
      $display("[TB] FAIL word_wr_port: got en=%0b we=%0b addr=%0d be=%04b, required 1 1 4 1111", en, we, a, be);
    end
    vectors++;
    if (wd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL word_wr_data: got %08h, required DEADBEEF", wd); end
  endtask

  task automatic test_byte_read();
    logic en, we; logic [9:0] a; logic [3:0] be; logic [31:0] wd;
    do_access(0, 1, 32'h10, 32'h80FF0000, 2'b10, 0, 32'h0, 0, 1, "preload", en, we, a, be, wd);
    do_access(0, 0, 32'h13, 32'h0, 2'b00, 1, 32'hFFFFFF80, 0, 2, "byte_rd_s", en, we, a, be, wd);
    vectors++;
    if ({en, we, a, be} !== {1'b1, 1'b0, 10'd4, 4'b1111}) begin
      miscompares++;
      $display("[TB] FAIL byte_rd_port: got en=%0b we=%0b addr=%0d be=%04b, required 1 0 4 1111", en, we, a, be);
    end
    do_access(0, 0, 32'h13, 32'h0, 2'b00, 0, 32'h00000080, 0, 2, "byte_rd_u", en, we, a, be, wd);
  endtask

  task automatic test_lanes();
    logic en, we; logic [9:0] a; logic [3:0] be; logic [31:0] wd;
    do_access(0, 1, 32'h06, 32'h1234ABCD, 2'b01, 0, 32'h0, 0, 1, "half_wr", en, we, a, be, wd);
    vectors++;
    if ({a, be, wd} !== {10'd1, 4'b1100, 32'hABCDABCD}) begin
      miscompares++;
      $display("[TB] FAIL half_wr_port: got addr=%0d be=%04b wdata=%08h, required 1 1100 ABCDABCD", a, be, wd);
    end
    do_access(1, 0, 32'h06, 32'h0, 2'b01, 1, 32'hFFFFABCD, 0, 2, "half_rd_s", en, we, a, be, wd);
    do_access(1, 1, 32'h05, 32'h00000077, 2'b00, 0, 32'h0, 0, 1, "byte_wr", en, we, a, be, wd);
    vectors++;
    if ({be, wd} !== {4'b0010, 32'h77777777}) begin
      miscompares++;
      $display("[TB] FAIL byte_wr_port: got be=%04b wdata=%08h, required 0010 77777777", be, wd);
    end
    do_access(0, 0, 32'h05, 32'h0, 2'b00, 0, 32'h00000077, 0, 2, "byte_rd_b1", en, we, a, be, wd);
    do_access(0, 0, 32'h04, 32'h0, 2'b01, 1, 32'h00007700, 0, 2, "half_rd_lo", en, we, a, be, wd);
    do_access(0, 1, 32'h20, 32'h11223344, 2'b11, 0, 32'h0, 0, 1, "size3_wr", en, we, a, be, wd);
    vectors++;
    if ({a, be, wd} !== {10'd8, 4'b1111, 32'h11223344}) begin
      miscompares++;
      $display("[TB] FAIL size3_wr_port: got addr=%0d be=%04b wdata=%08h, required 8 1111 11223344", a, be, wd);
    end
    do_access(0, 0, 32'h20, 32'h0, 2'b11, 1, 32'h11223344, 0, 2, "size3_rd", en, we, a, be, wd);
    do_access(1, 0, 32'h1010, 32'h0, 2'b10, 0, 32'h80FF0000, 0, 2, "wrap_rd", en, we, a, be, wd);
    vectors++;
    if (a !== 10'd4) begin miscompares++; $display("[TB] FAIL wrap_addr: got %0d, required 4", a); end
  endtask

  task automatic test_misaligned();
    logic en, we; logic [9:0] a; logic [3:0] be; logic [31:0] wd;
    do_access(1, 0, 32'h02, 32'h0, 2'b10, 0, 32'h0, 1, 1, "mis_word_rd", en, we, a, be, wd);
    vectors++;
    if (en !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_word_en: got %0b, required 0", en); end
    do_access(0, 1, 32'h01, 32'hFFFFFFFF, 2'b01, 0, 32'h0, 1, 1, "mis_half_wr", en, we, a, be, wd);
    vectors++;
    if (en !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_half_en: got %0b, required 0", en); end
  endtask

  task automatic test_arbitration();
    apply_reset();
    for (int i = 0; i < 6; i++) sb.push_back('{is_d: (i % 2 == 1), rdata: 32'h0, err: 1'b0});
    @(posedge clk); #1;
    c_req = 1; c_we = 1; c_addr = 32'h40; c_wdata = 32'hC0C0C0C0; c_size = 2'b10;
    d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'hD0D0D0D0; d_size = 2'b10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (nf_d_ack !== 1'b0 || nf_c_ack !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL fixed_prio cycle %0d: got c_ack=%0b d_ack=%0b, required 1 0", i, nf_c_ack, nf_d_ack);
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset_during_rd();
    logic en, we; logic [9:0] a; logic [3:0] be; logic [31:0] wd;
    @(posedge clk); #1;
    c_req = 1; c_we = 0; c_addr = 32'h10; c_size = 2'b10; c_sign = 0;
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b1) begin miscompares++; $display("[TB] FAIL rdrst_strobe: got %0b, required 1", mem_en); end
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    vectors++;
    if (c_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL rdrst_ack: got %0b, required 0", c_ack); end
    c_req = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    vectors++;
    if ({c_ack, d_ack, mem_en} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL rdrst_idle: got c_ack=%0b d_ack=%0b mem_en=%0b, required 0", c_ack, d_ack, mem_en);
    end
    do_access(0, 0, 32'h10, 32'h0, 2'b10, 0, 32'h80FF0000, 0, 2, "rdrst_reissue", en, we, a, be, wd);
    vectors++;
    if (en !== 1'b1) begin miscompares++; $display("[TB] FAIL rdrst_reaccess: got %0b, required 1", en); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    test_reset();
    test_word_write();
    test_byte_read();
    test_lanes();
    test_misaligned();
    test_arbitration();
    test_reset_during_rd();
    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d acks outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_dmem_arbiter.md
Name: sr_dmem_arbiter

Overview:
- Shares one synchronous single-port data RAM between two requesters: the CPU data port (requester C) and a debug/loader port (requester D).
- Arbitrates between the two, either round-robin or with fixed CPU priority.
- Converts byte/half/word accesses into a word address, byte enables and lane-aligned write data. Read data is sign- or zero-extended.
- Provides the per-requester ack that the core uses to stall its PC (stall = c_req & ~c_ack).

Parameters:
- AW, 10, RAM word-address width; mem_addr = addr[AW+1:2].
- FAIR, 1, 1 = round-robin; 0 = C always wins when both request.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- c_req  in  1  C request; held with c_* fields stable until c_ack
- c_we  in  1  C write (1) / read (0)
- c_addr  in  32  C byte address
- c_wdata  in  32  C write data, right-justified
- c_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- c_sign  in  1  sign-extend read data
- c_ack  out  1  C transaction complete this cycle
- c_rdata  out  32  C read data, valid while c_ack on a read, else 0
- c_err  out  1  misaligned access, qualified by c_ack
- d_req, d_we, d_addr, d_wdata, d_size, d_sign, d_ack, d_rdata, d_err: same as c_*, for requester D
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write
- mem_addr  out  AW  RAM word address
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  RAM read data, valid the cycle after a read strobe

Behaviour:
- Single clock; reset is asynchronous and active-low on rst_n. Reset gives state = IDLE and last = D, so C wins the first tie.
- All outputs are combinational from state and inputs. All outputs are 0 in reset and whenever no request is in progress.
- State IDLE, winner selection:
  - One requester active: it wins.
  - Both active and FAIR=1: the requester other than `last` wins.
  - Both active and FAIR=0: C wins.
- State IDLE, actions for the winner:
  - Misaligned access (half with addr[0]=1; word with addr[1:0]≠0): ack=1, err=1, rdata=0, mem_en=0, last←winner, stay IDLE.
  - Write: mem_en=1, mem_we=1, ack=1 in the same cycle, last←winner, stay IDLE. Latency is 1 cycle.
  - Read: mem_en=1, mem_we=0, mem_be=1111. Register the winner id, addr[1:0], size and sign, then go to RD. No ack in IDLE.
- State RD:
  - mem_en=0.
  - Winner's ack=1; rdata = extended mem_rdata.
  - last←winner, then go to IDLE. Read latency is 2 cycles from request to ack.
  - The loser is not serviced in RD; it is serviced at the earliest in the following IDLE cycle.
- Write lanes:
  - byte: be = 0001<<addr[1:0], wdata = {4{w[7:0]}}
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{w[15:0]}}
  - word: be = 1111, wdata = w
- Read extract:
  - byte: mem_rdata >> (8*off), bits [7:0]
  - half: mem_rdata >> (16*off[1]), bits [15:0]
  - Result is sign-extended if sign=1, else zero-extended.
- The ack of the non-winner is always 0. At most one ack is high per cycle.
- If the requester drops req while in RD, the access still completes and the ack is still pulsed. This is a protocol violation and must not corrupt state.
- Reset during RD: return to IDLE immediately and emit no ack. On the next request the RAM is re-accessed.
- mem_addr wraps modulo 2^AW; the upper address bits are ignored.
- size=11 behaves exactly as word.

Test Plan:
- C word write addr 0x10 data 0xDEADBEEF -> same cycle: mem_en=1, mem_we=1, mem_addr=4, mem_be=1111, c_ack=1, c_err=0.
- C byte read addr 0x13 sign=1, RAM word4=0x80FF_0000 -> cycle+1: c_ack=1, c_rdata=0xFFFFFF80. Same access with sign=0 -> 0x00000080.
- Half write addr 0x06 data 0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=1.
- C and D both continuously issue word writes, FAIR=1 -> acks alternate C,D,C,D starting with C. Same stimulus with FAIR=0 -> D never acked while c_req is held.
- D word read addr 0x02 -> d_ack=1, d_err=1, d_rdata=0, mem_en never asserted.
- C read issued, rst_n pulled low during RD -> no c_ack. After release, state is IDLE and the re-issued read returns correct data 2 cycles later.
